// File: rtl/lsu.sv
// Load/store unit: one outstanding data-memory access over req/gnt/rvalid,
// with store lane alignment, load extraction/extension and access exceptions.
module lsu #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             clk_en_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_store_i,
  input  logic [2:0]       req_funct3_i,
  input  logic [XLEN-1:0]  req_addr_i,
  input  logic [XLEN-1:0]  req_wdata_i,
  input  logic [TAG_W-1:0] req_tag_i,
  output logic             dmem_req_o,
  input  logic             dmem_gnt_i,
  output logic [XLEN-1:0]  dmem_addr_o,
  output logic             dmem_we_o,
  output logic [3:0]       dmem_be_o,
  output logic [XLEN-1:0]  dmem_wdata_o,
  input  logic             dmem_rvalid_i,
  input  logic [XLEN-1:0]  dmem_rdata_i,
  output logic             resp_valid_o,
  output logic             resp_we_o,
  output logic [TAG_W-1:0] resp_tag_o,
  output logic [XLEN-1:0]  resp_data_o,
  output logic             excp_valid_o,
  output logic [1:0]       excp_cause_o,
  output logic [XLEN-1:0]  excp_addr_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

  state_e             state_q, state_d;
  logic               store_q, store_d;
  logic [2:0]         funct3_q, funct3_d;
  logic [1:0]         addr_lo_q, addr_lo_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic               dmem_req_q, dmem_req_d;
  logic [XLEN-1:0]    dmem_addr_q, dmem_addr_d;
  logic               dmem_we_q, dmem_we_d;
  logic [3:0]         dmem_be_q, dmem_be_d;
  logic [XLEN-1:0]    dmem_wdata_q, dmem_wdata_d;
  logic               resp_valid_q, resp_valid_d;
  logic               resp_we_q, resp_we_d;
  logic [TAG_W-1:0]   resp_tag_q, resp_tag_d;
  logic [XLEN-1:0]    resp_data_q, resp_data_d;
  logic               excp_valid_q, excp_valid_d;
  logic [1:0]         excp_cause_q, excp_cause_d;
  logic [XLEN-1:0]    excp_addr_q, excp_addr_d;

  logic               illegal_c, misalign_c;
  logic [3:0]         be_c;
  logic [XLEN-1:0]    wdata_c;
  logic [7:0]         ld_byte_c;
  logic [15:0]        ld_half_c;
  logic [XLEN-1:0]    ld_data_c;

  // Request decode: legality, alignment, and store lane placement.
  always_comb begin
    if (req_store_i) illegal_c = (req_funct3_i > 3'd2);
    else             illegal_c = (req_funct3_i == 3'b011) || (req_funct3_i[2:1] == 2'b11);
    misalign_c = ((req_funct3_i[1:0] == 2'b01) && req_addr_i[0]) ||
                 ((req_funct3_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00));
    be_c    = 4'b1111;
    wdata_c = req_wdata_i;
    if (req_store_i) begin
      case (req_funct3_i[1:0])
        2'b00: begin
          be_c    = 4'b0001 << req_addr_i[1:0];
          wdata_c = {(XLEN/8){req_wdata_i[7:0]}};
        end
        2'b01: begin
          be_c    = 4'b0011 << {req_addr_i[1], 1'b0};
          wdata_c = {(XLEN/16){req_wdata_i[15:0]}};
        end
        default: ;
      endcase
    end
  end

  // Load lane extraction and sign/zero extension.
  always_comb begin
    ld_byte_c = dmem_rdata_i[{addr_lo_q, 3'b000} +: 8];
    ld_half_c = dmem_rdata_i[{addr_lo_q[1], 4'b0000} +: 16];
    case (funct3_q)
      3'b000:  ld_data_c = {{(XLEN-8){ld_byte_c[7]}}, ld_byte_c};
      3'b001:  ld_data_c = {{(XLEN-16){ld_half_c[15]}}, ld_half_c};
      3'b100:  ld_data_c = {{(XLEN-8){1'b0}}, ld_byte_c};
      3'b101:  ld_data_c = {{(XLEN-16){1'b0}}, ld_half_c};
      default: ld_data_c = dmem_rdata_i;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    store_d      = store_q;
    funct3_d     = funct3_q;
    addr_lo_d    = addr_lo_q;
    tag_d        = tag_q;
    dmem_req_d   = dmem_req_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_we_d    = dmem_we_q;
    dmem_be_d    = dmem_be_q;
    dmem_wdata_d = dmem_wdata_q;
    resp_valid_d = 1'b0;
    resp_we_d    = resp_we_q;
    resp_tag_d   = resp_tag_q;
    resp_data_d  = resp_data_q;
    excp_valid_d = 1'b0;
    excp_cause_d = excp_cause_q;
    excp_addr_d  = excp_addr_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          store_d   = req_store_i;
          funct3_d  = req_funct3_i;
          addr_lo_d = req_addr_i[1:0];
          tag_d     = req_tag_i;
          if (illegal_c || misalign_c) begin
            excp_valid_d = 1'b1;
            excp_cause_d = illegal_c ? 2'b10 : 2'b01;
            excp_addr_d  = req_addr_i;
          end else begin
            state_d      = REQ;
            dmem_req_d   = 1'b1;
            dmem_addr_d  = {req_addr_i[XLEN-1:2], 2'b00};
            dmem_we_d    = req_store_i;
            dmem_be_d    = be_c;
            dmem_wdata_d = wdata_c;
          end
        end
      end
      REQ: begin
        if (dmem_gnt_i) begin
          dmem_req_d = 1'b0;
          dmem_we_d  = 1'b0;
          if (store_q) begin
            state_d      = IDLE;
            resp_valid_d = 1'b1;
            resp_we_d    = 1'b0;
            resp_tag_d   = tag_q;
            resp_data_d  = '0;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (dmem_rvalid_i) begin
          state_d      = IDLE;
          resp_valid_d = 1'b1;
          resp_we_d    = 1'b1;
          resp_tag_d   = tag_q;
          resp_data_d  = ld_data_c;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // All state frozen while the pipeline clock enable is low.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      store_q      <= 1'b0;
      funct3_q     <= '0;
      addr_lo_q    <= '0;
      tag_q        <= '0;
      dmem_req_q   <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_we_q    <= 1'b0;
      dmem_be_q    <= '0;
      dmem_wdata_q <= '0;
      resp_valid_q <= 1'b0;
      resp_we_q    <= 1'b0;
      resp_tag_q   <= '0;
      resp_data_q  <= '0;
      excp_valid_q <= 1'b0;
      excp_cause_q <= '0;
      excp_addr_q  <= '0;
    end else if (clk_en_i) begin
      state_q      <= state_d;
      store_q      <= store_d;
      funct3_q     <= funct3_d;
      addr_lo_q    <= addr_lo_d;
      tag_q        <= tag_d;
      dmem_req_q   <= dmem_req_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_we_q    <= dmem_we_d;
      dmem_be_q    <= dmem_be_d;
      dmem_wdata_q <= dmem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_we_q    <= resp_we_d;
      resp_tag_q   <= resp_tag_d;
      resp_data_q  <= resp_data_d;
      excp_valid_q <= excp_valid_d;
      excp_cause_q <= excp_cause_d;
      excp_addr_q  <= excp_addr_d;
    end
  end

  assign req_ready_o  = (state_q == IDLE);
  assign dmem_req_o   = dmem_req_q;
  assign dmem_addr_o  = dmem_addr_q;
  assign dmem_we_o    = dmem_we_q;
  assign dmem_be_o    = dmem_be_q;
  assign dmem_wdata_o = dmem_wdata_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_we_o    = resp_we_q;
  assign resp_tag_o   = resp_tag_q;
  assign resp_data_o  = resp_data_q;
  assign excp_valid_o = excp_valid_q;
  assign excp_cause_o = excp_cause_q;
  assign excp_addr_o  = excp_addr_q;

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: expected responses are queued at issue and
// matched against resp/excp pulses by a monitor.
module tb_lsu;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned TAG_W = 5;

  logic             clk, reset_i, clk_en_i;
  logic             req_valid_i, req_ready_o, req_store_i;
  logic [2:0]       req_funct3_i;
  logic [XLEN-1:0]  req_addr_i, req_wdata_i;
  logic [TAG_W-1:0] req_tag_i;
  logic             dmem_req_o, dmem_gnt_i, dmem_we_o, dmem_rvalid_i;
  logic [XLEN-1:0]  dmem_addr_o, dmem_wdata_o, dmem_rdata_i;
  logic [3:0]       dmem_be_o;
  logic             resp_valid_o, resp_we_o, excp_valid_o;
  logic [TAG_W-1:0] resp_tag_o;
  logic [XLEN-1:0]  resp_data_o, excp_addr_o;
  logic [1:0]       excp_cause_o;

  lsu #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk_i(clk), .reset_i(reset_i), .clk_en_i(clk_en_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_store_i(req_store_i),
    .req_funct3_i(req_funct3_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .req_tag_i(req_tag_i), .dmem_req_o(dmem_req_o), .dmem_gnt_i(dmem_gnt_i),
    .dmem_addr_o(dmem_addr_o), .dmem_we_o(dmem_we_o), .dmem_be_o(dmem_be_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .resp_valid_o(resp_valid_o), .resp_we_o(resp_we_o), .resp_tag_o(resp_tag_o),
    .resp_data_o(resp_data_o), .excp_valid_o(excp_valid_o), .excp_cause_o(excp_cause_o),
    .excp_addr_o(excp_addr_o)
  );

  typedef struct {
    logic        excp;
    logic        we;
    logic [4:0]  tag;
    logic [31:0] data;
    logic [1:0]  cause;
    logic [31:0] addr;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int checks = 0;
  int failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Response monitor: each enabled pulse cycle consumes one expectation.
  always @(negedge clk) begin
    if (!reset_i && clk_en_i && (resp_valid_o || excp_valid_o)) begin
      checks++;
      if (resp_valid_o && excp_valid_o) begin
        failures++;
        $display("FAIL pulse_overlap resp=%0b excp=%0b required one only", resp_valid_o, excp_valid_o);
      end else if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse resp=%0b excp=%0b tag=%0d required no pulse",
                 resp_valid_o, excp_valid_o, resp_tag_o);
      end else begin
        mon_e = sb_q.pop_front();
        if (mon_e.excp) begin
          if (excp_valid_o !== 1'b1 || excp_cause_o !== mon_e.cause || excp_addr_o !== mon_e.addr) begin
            failures++;
            $display("FAIL excp got valid=%0b cause=%b addr=%h required valid=1 cause=%b addr=%h",
                     excp_valid_o, excp_cause_o, excp_addr_o, mon_e.cause, mon_e.addr);
          end
        end else if (resp_valid_o !== 1'b1 || resp_we_o !== mon_e.we ||
                     resp_tag_o !== mon_e.tag || resp_data_o !== mon_e.data) begin
          failures++;
          $display("FAIL resp got valid=%0b we=%0b tag=%0d data=%h required valid=1 we=%0b tag=%0d data=%h",
                   resp_valid_o, resp_we_o, resp_tag_o, resp_data_o, mon_e.we, mon_e.tag, mon_e.data);
        end
      end
    end
  end

  function automatic exp_t predict(input logic st, input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] rd, input logic [4:0] tg);
    exp_t e;
    logic [7:0]  b;
    logic [15:0] h;
    logic [1:0]  sz;
    sz = f3[1:0];
    e.excp = 1'b0; e.we = !st; e.tag = tg; e.data = 32'h0; e.cause = 2'b00; e.addr = 32'h0;
    if (st ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) begin
      e.excp = 1'b1; e.cause = 2'b10; e.addr = a;
    end else if ((sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0)) begin
      e.excp = 1'b1; e.cause = 2'b01; e.addr = a;
    end else if (!st) begin
      case (a[1:0])
        2'd0: b = rd[7:0];
        2'd1: b = rd[15:8];
        2'd2: b = rd[23:16];
        default: b = rd[31:24];
      endcase
      h = a[1] ? rd[31:16] : rd[15:0];
      case (f3)
        3'd0: e.data = {{24{b[7]}}, b};
        3'd1: e.data = {{16{h[15]}}, h};
        3'd4: e.data = {24'h0, b};
        3'd5: e.data = {16'h0, h};
        default: e.data = rd;
      endcase
    end
    return e;
  endfunction

  function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] a);
    if (f3 == 3'd0) begin
      case (a[1:0])
        2'd0: return 4'b0001;
        2'd1: return 4'b0010;
        2'd2: return 4'b0100;
        default: return 4'b1000;
      endcase
    end
    if (f3 == 3'd1) return a[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] exp_wd(input logic [2:0] f3, input logic [31:0] w);
    if (f3 == 3'd0) return {4{w[7:0]}};
    if (f3 == 3'd1) return {2{w[15:0]}};
    return w;
  endfunction

  // Issue one op, play the memory side, and stop on the cycle its result is visible.
  task automatic do_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] tg, input logic [31:0] rdv,
                       input int gd, input int rdl, input int fz);
    exp_t e;
    int cyc;
    logic [3:0]  be_e;
    logic [31:0] wd_e;
    e = predict(st, f3, a, rdv, tg);
    sb_q.push_back(e);
    checks++;
    if (req_ready_o !== 1'b1) begin
      failures++; $display("FAIL ready got=%0b required=1", req_ready_o);
    end
    req_valid_i = 1'b1; req_store_i = st; req_funct3_i = f3; req_addr_i = a;
    req_wdata_i = wd; req_tag_i = tg;
    tick();
    req_valid_i = 1'b0; req_addr_i = $urandom; req_wdata_i = $urandom;
    req_funct3_i = 3'($urandom); req_tag_i = 5'($urandom);
    if (e.excp) begin
      checks++;
      if (dmem_req_o !== 1'b0 || excp_valid_o !== 1'b1) begin
        failures++;
        $display("FAIL excp_issue got req=%0b excp=%0b required req=0 excp=1", dmem_req_o, excp_valid_o);
      end
      return;
    end
    be_e = st ? exp_be(f3, a) : 4'b1111;
    wd_e = exp_wd(f3, wd);
    checks++;
    if (dmem_req_o !== 1'b1 || dmem_addr_o !== {a[31:2], 2'b00} || dmem_we_o !== st ||
        dmem_be_o !== be_e || (st && dmem_wdata_o !== wd_e)) begin
      failures++;
      $display("FAIL dmem_issue got req=%0b addr=%h we=%0b be=%b wd=%h required req=1 addr=%h we=%0b be=%b wd=%h",
               dmem_req_o, dmem_addr_o, dmem_we_o, dmem_be_o, dmem_wdata_o,
               {a[31:2], 2'b00}, st, be_e, wd_e);
    end
    cyc = 0;
    repeat (gd) begin
      if (dmem_req_o === 1'b1) cyc++;
      dmem_rvalid_i = 1'b1; dmem_rdata_i = $urandom;
      tick();
    end
    dmem_rvalid_i = 1'b0;
    dmem_gnt_i = 1'b1;
    checks++;
    if (dmem_be_o !== be_e || dmem_addr_o !== {a[31:2], 2'b00} || dmem_we_o !== st) begin
      failures++;
      $display("FAIL dmem_hold got be=%b addr=%h we=%0b required be=%b addr=%h we=%0b",
               dmem_be_o, dmem_addr_o, dmem_we_o, be_e, {a[31:2], 2'b00}, st);
    end
    if (dmem_req_o === 1'b1) cyc++;
    tick();
    dmem_gnt_i = 1'b0;
    checks++;
    if (cyc != gd + 1 || dmem_req_o !== 1'b0) begin
      failures++;
      $display("FAIL req_cycles got cycles=%0d req_after=%0b required cycles=%0d req_after=0",
               cyc, dmem_req_o, gd + 1);
    end
    if (!st) begin
      repeat (rdl - 1) tick();
      dmem_rvalid_i = 1'b1; dmem_rdata_i = rdv;
      if (fz > 0) begin
        clk_en_i = 1'b0;
        repeat (fz) begin
          tick();
          checks++;
          if (resp_valid_o !== 1'b0 || req_ready_o !== 1'b0 || dmem_req_o !== 1'b0) begin
            failures++;
            $display("FAIL freeze got resp=%0b ready=%0b req=%0b required 0 0 0",
                     resp_valid_o, req_ready_o, dmem_req_o);
          end
        end
        clk_en_i = 1'b1;
      end
      tick();
      dmem_rvalid_i = 1'b0; dmem_rdata_i = $urandom;
    end
    checks++;
    if (resp_valid_o !== 1'b1) begin
      failures++; $display("FAIL resp_latency got resp_valid=%0b required=1", resp_valid_o);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      failures++; $display("FAIL drain pending=%0d required=0", sb_q.size());
      sb_q.delete();
    end
    tick();
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (dmem_req_o !== 1'b0 || dmem_we_o !== 1'b0 || dmem_be_o !== 4'b0000) begin
      failures++; $display("FAIL reset_dmem got req=%0b we=%0b be=%b required 0 0 0000",
                           dmem_req_o, dmem_we_o, dmem_be_o);
    end
    checks++;
    if (resp_valid_o !== 1'b0 || resp_we_o !== 1'b0 || excp_valid_o !== 1'b0) begin
      failures++; $display("FAIL reset_pulses got resp=%0b we=%0b excp=%0b required 0 0 0",
                           resp_valid_o, resp_we_o, excp_valid_o);
    end
    checks++;
    if (dmem_addr_o !== 32'h0 || dmem_wdata_o !== 32'h0 || resp_data_o !== 32'h0 ||
        resp_tag_o !== 5'h0 || excp_addr_o !== 32'h0 || excp_cause_o !== 2'b00) begin
      failures++; $display("FAIL reset_data got addr=%h wd=%h rd=%h tag=%0d ea=%h cause=%b required all 0",
                           dmem_addr_o, dmem_wdata_o, resp_data_o, resp_tag_o, excp_addr_o, excp_cause_o);
    end
    checks++;
    if (req_ready_o !== 1'b1) begin
      failures++; $display("FAIL reset_ready got=%0b required=1", req_ready_o);
    end
    tick();
    reset_i = 1'b0;
    tick();
  endtask

  task automatic test_store();
    do_op(1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 5'd1, 32'h0, 0, 1, 0);
    drain();
    do_op(1'b1, 3'd0, 32'h103, 32'h000000A5, 5'd2, 32'h0, 1, 1, 0);
    drain();
    do_op(1'b1, 3'd1, 32'h102, 32'h1234ABCD, 5'd3, 32'h0, 2, 1, 0);
    drain();
    do_op(1'b1, 3'd0, 32'h000, 32'h87654312, 5'd4, 32'h0, 0, 1, 0);
    drain();
  endtask

  task automatic test_load();
    do_op(1'b0, 3'd0, 32'h201, 32'h0, 5'd7, 32'h00008000, 3, 2, 0);
    drain();
    do_op(1'b0, 3'd4, 32'h201, 32'h0, 5'd9, 32'h00008000, 3, 2, 0);
    drain();
    do_op(1'b0, 3'd1, 32'h302, 32'h0, 5'd11, 32'h80011234, 0, 1, 0);
    drain();
    do_op(1'b0, 3'd5, 32'h300, 32'h0, 5'd12, 32'h80019234, 1, 1, 0);
    drain();
    do_op(1'b0, 3'd2, 32'h304, 32'h0, 5'd13, 32'hCAFEF00D, 0, 3, 0);
    drain();
    do_op(1'b0, 3'd0, 32'hFFFFFFFF, 32'h0, 5'd31, 32'h7F000000, 1, 1, 0);
    drain();
  endtask

  task automatic test_exceptions();
    do_op(1'b0, 3'd2, 32'h301, 32'h0, 5'd5, 32'h0, 0, 1, 0);
    drain();
    do_op(1'b0, 3'd3, 32'h40, 32'h0, 5'd6, 32'h0, 0, 1, 0);
    drain();
    do_op(1'b1, 3'd4, 32'h44, 32'h0, 5'd6, 32'h0, 0, 1, 0);
    drain();
    do_op(1'b1, 3'd1, 32'h101, 32'h0, 5'd6, 32'h0, 0, 1, 0);
    drain();
    do_op(1'b0, 3'd6, 32'h48, 32'h0, 5'd6, 32'h0, 0, 1, 0);
    drain();
  endtask

  task automatic test_back_to_back();
    do_op(1'b0, 3'd2, 32'h400, 32'h0, 5'd20, 32'h11223344, 0, 1, 2);
    do_op(1'b0, 3'd0, 32'h402, 32'h0, 5'd21, 32'h00800000, 0, 2, 0);
    do_op(1'b1, 3'd1, 32'h406, 32'hAAAA5555, 5'd22, 32'h0, 1, 1, 0);
    do_op(1'b0, 3'd1, 32'h407, 32'h0, 5'd23, 32'h0, 0, 1, 0);
    do_op(1'b0, 3'd5, 32'h40A, 32'h0, 5'd24, 32'hFEDC0000, 0, 1, 1);
    drain();
  endtask

  task automatic test_reset_mid();
    req_valid_i = 1'b1; req_store_i = 1'b0; req_funct3_i = 3'd2;
    req_addr_i = 32'h500; req_tag_i = 5'd15;
    tick();
    req_valid_i = 1'b0;
    dmem_gnt_i = 1'b1;
    tick();
    dmem_gnt_i = 1'b0;
    tick();
    reset_i = 1'b1;
    #1;
    checks++;
    if (dmem_req_o !== 1'b0 || dmem_be_o !== 4'b0000 || dmem_addr_o !== 32'h0 || req_ready_o !== 1'b1) begin
      failures++; $display("FAIL reset_mid got req=%0b be=%b addr=%h ready=%0b required 0 0000 0 1",
                           dmem_req_o, dmem_be_o, dmem_addr_o, req_ready_o);
    end
    tick();
    reset_i = 1'b0;
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h12345678;
    tick();
    dmem_rvalid_i = 1'b0;
    checks++;
    if (resp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
      failures++; $display("FAIL late_rvalid got resp=%0b ready=%0b required 0 1", resp_valid_o, req_ready_o);
    end
    tick();
    checks++;
    if (resp_valid_o !== 1'b0 || excp_valid_o !== 1'b0) begin
      failures++; $display("FAIL late_rvalid_after got resp=%0b excp=%0b required 0 0", resp_valid_o, excp_valid_o);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i = 1'b1; clk_en_i = 1'b1;
    req_valid_i = 1'b0; req_store_i = 1'b0; req_funct3_i = 3'd0;
    req_addr_i = 32'h0; req_wdata_i = 32'h0; req_tag_i = 5'd0;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'h0;
    test_reset();
    test_store();
    test_load();
    test_exceptions();
    test_back_to_back();
    test_reset_mid();
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store unit directly downstream of the ALU.
- Takes the registered ALU result as the effective address and issues a single outstanding data-memory transaction over a req/gnt/rvalid handshake.
- Aligns store data and byte enables; extracts and sign/zero-extends load data.
- Returns a registered writeback response to the pipeline, or an exception for misaligned or illegal accesses.

Parameters:
- XLEN, 32, data/address width (equals `RV_XLEN).
- TAG_W, 5, width of the destination-register tag carried through to the response.

Ports:
- clk_i  in  1  clock; all state on rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- clk_en_i  in  1  pipeline clock enable; 0 freezes all state and registered outputs.
- req_valid_i  in  1  execute stage presents a memory op.
- req_ready_o  out  1  LSU can accept (high only in IDLE).
- req_store_i  in  1  1 = store, 0 = load.
- req_funct3_i  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- req_addr_i  in  XLEN  effective address (ALU op result).
- req_wdata_i  in  XLEN  store data (rs2).
- req_tag_i  in  TAG_W  destination register index.
- dmem_req_o  out  1  memory request.
- dmem_gnt_i  in  1  memory accepts request this cycle.
- dmem_addr_o  out  XLEN  word-aligned address {addr[XLEN-1:2],2'b00}.
- dmem_we_o  out  1  write enable.
- dmem_be_o  out  4  byte enables.
- dmem_wdata_o  out  XLEN  lane-replicated store data.
- dmem_rvalid_i  in  1  read data valid.
- dmem_rdata_i  in  XLEN  read data word.
- resp_valid_o  out  1  one-cycle response pulse.
- resp_we_o  out  1  response writes register file (loads only).
- resp_tag_o  out  TAG_W  destination tag.
- resp_data_o  out  XLEN  extended load data (0 for stores).
- excp_valid_o  out  1  one-cycle exception pulse.
- excp_cause_o  out  2  01 misaligned, 10 illegal funct3.
- excp_addr_o  out  XLEN  faulting address.

Behaviour:
- Reset (async, while reset_i=1):
  - state=IDLE; dmem_req_o, dmem_we_o, resp_valid_o, resp_we_o, excp_valid_o = 0.
  - dmem_be_o = 4'b0000; all data/address/tag outputs = 0.
- clk_en_i=0: no state, register or output change. Memory must hold gnt/rvalid until sampled with clk_en_i=1.
- FSM states: IDLE, REQ, WAIT.
- IDLE:
  - Accepts on req_valid_i & clk_en_i. The request is latched: addr, funct3, store flag, tag, wdata.
  - Illegal funct3 (loads 011/110/111; stores >010): no memory request; next cycle excp_valid_o=1, cause 10, stay IDLE.
  - Misaligned (half with addr[0]=1, word with addr[1:0]!=0): no memory request; next cycle excp_valid_o=1, cause 01, stay IDLE.
  - Otherwise: go to REQ with dmem_req_o=1 registered, i.e. the cycle after acceptance.
- REQ:
  - dmem_req_o and all dmem_* outputs held stable until dmem_gnt_i.
  - Byte enables:
    - SB: 4'b0001<<addr[1:0].
    - SH: 4'b0011<<{addr[1],1'b0}.
    - SW and all loads: 4'b1111.
  - Store data replication:
    - SB: wdata[7:0] replicated x4.
    - SH: wdata[15:0] replicated x2.
    - SW: unchanged.
  - On gnt, store: dmem_req_o drops next cycle; resp_valid_o=1, resp_we_o=0, resp_data_o=0 next cycle; go to IDLE.
  - On gnt, load: dmem_req_o drops; go to WAIT.
  - dmem_rvalid_i in REQ is ignored.
- WAIT (rvalid must arrive ≥1 cycle after gnt):
  - On dmem_rvalid_i, go to IDLE. Next cycle: resp_valid_o=1, resp_we_o=1, resp_tag_o=tag.
  - resp_data_o:
    - Byte = rdata>>(8*addr[1:0]); half = rdata>>(16*addr[1]).
    - LB/LH sign-extend; LBU/LHU zero-extend; LW unchanged.
- Latency:
  - Store: accept→resp 2 cycles + gnt wait.
  - Load: accept→req 1, gnt→rvalid ≥1, rvalid→resp 1.
  - Exception: accept→excp 1 cycle.
- req_ready_o:
  - Combinational = (state==IDLE).
  - A new request may be accepted in the same cycle a resp/excp pulse is driven.
- Pulses: resp_valid_o and excp_valid_o are exactly one enabled cycle wide and never asserted together.
- Reset mid-transaction: state returns to IDLE, dmem_req_o=0, no response emitted. A late rvalid arriving in IDLE is ignored.
- Address wrap: none; address is passed through modulo 2^XLEN.

Test Plan:
- SW addr 0x100, data 0xDEADBEEF, gnt same cycle req rises:
  - dmem_be_o=1111, wdata 0xDEADBEEF, we=1.
  - resp_valid_o 1 cycle later, resp_we_o=0.
- SB addr 0x103, data 0x000000A5:
  - be=1000, wdata=0xA5A5A5A5.
- LB addr 0x201, rdata 0x0000_80_00, gnt delayed 3 cycles, rvalid 2 cycles after gnt:
  - resp_data_o=0xFFFFFF80, tag preserved, dmem_req_o held 4 cycles.
  - LBU same stimulus → 0x00000080.
- LH addr 0x302:
  - rdata 0x8001_1234 → 0xFFFF8001.
  - LW addr 0x301 → no dmem_req_o; excp_valid_o=1, cause 01, excp_addr_o=0x301.
- Load funct3=011 → excp cause 10, no memory request.
- Back-to-back loads:
  - clk_en_i=0 for 2 cycles during WAIT: outputs frozen, response delayed 2 cycles.
- reset_i pulsed during WAIT:
  - Outputs zero immediately.
  - A subsequent rvalid produces no resp_valid_o.
